ntt_agu: RTL and testbench

NTT_AGU -- requirements
Module: ntt_agu

---
 rtl/ntt_agu_pkg.sv | 13 +
 rtl/ntt_agu_dly.sv | 24 ++
 rtl/ntt_agu.sv | 113 +++++++++++
 tb/tb_ntt_agu.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ntt_agu_pkg.sv
// ntt_agu_pkg: FSM encoding and bank-index constants shared by the NTT address generator
package ntt_agu_pkg;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    localparam logic [1:0] PAIR0_BASE = 2'd0;
    localparam logic [1:0] PAIR1_BASE = 2'd2;

    function automatic logic [1:0] dst_bank(input logic pair, input logic hi);
        return (pair ? PAIR0_BASE : PAIR1_BASE) | {1'b0, hi};
    endfunction

endpackage

// File: rtl/ntt_agu_dly.sv
// ntt_agu_dly: DEPTH-deep valid shift register that freezes while hold is high
module ntt_agu_dly
    import ntt_agu_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    input  logic din,
    output logic dout
);

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            sr <= '0;
        else if (!hold)
            sr <= DEPTH'({sr, din});

    assign dout = sr[DEPTH-1];

endmodule

// File: rtl/ntt_agu.sv
// ntt_agu: in-place NTT/INTT read, write and twiddle address generator over four ping-pong banks
module ntt_agu
    import ntt_agu_pkg::*;
#(
    parameter int LOGN    = 8,
    parameter int BFU_LAT = 3,
    parameter int AW      = LOGN - 1,
    parameter int TW_AW   = $clog2(LOGN * (2 ** LOGN) / 2)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       inverse,
    input  logic                       hold,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(LOGN+1)-1:0]  stage,
    output logic                       rd_en,
    output logic                       rd_pair,
    output logic [AW-1:0]              rd_addr,
    output logic                       tw_en,
    output logic [TW_AW-1:0]           tw_addr,
    output logic                       wr_en,
    output logic [1:0]                 wr_bank,
    output logic [AW-1:0]              wr_addr0,
    output logic [AW-1:0]              wr_addr1
);

    localparam int HALF    = 2 ** (LOGN - 1);
    localparam int QTR     = HALF / 2;
    localparam int SW      = $clog2(LOGN + 1);
    localparam int DW      = $clog2(BFU_LAT + 1);
    localparam int TW_LAST = LOGN * HALF - 1;

    state_t          state;
    logic [AW-1:0]   k;
    logic [AW-1:0]   j;
    logic [AW-1:0]   m;
    logic [DW-1:0]   d;
    logic            inv;
    logic            wr_raw;
    logic            hi;
    logic [31:0]     tw_idx;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            stage <= '0;
            k     <= '0;
            d     <= '0;
            inv   <= 1'b0;
        end else if (!hold) begin
            case (state)
                IDLE: if (start) begin
                    state <= READ;
                    stage <= '0;
                    k     <= '0;
                    inv   <= inverse;
                end
                READ: begin
                    k <= (k == AW'(HALF - 1)) ? '0 : k + 1'b1;
                    if (k == AW'(HALF - 1)) begin
                        state <= DRAIN;
                        d     <= '0;
                    end
                end
                DRAIN: begin
                    d <= d + 1'b1;
                    if (d == DW'(BFU_LAT - 1)) begin
                        if (stage == SW'(LOGN - 1))
                            state <= DONE;
                        else begin
                            stage <= stage + 1'b1;
                            state <= READ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end

    ntt_agu_dly #(.DEPTH(BFU_LAT)) u_dly (
        .clk  (clk),
        .rst_n(rst_n),
        .hold (hold),
        .din  (rd_en),
        .dout (wr_raw)
    );

    // Write index j: first half fills the lower bank of the opposite pair, second half the upper.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            j <= '0;
        else if (!hold && wr_raw)
            j <= (j == AW'(HALF - 1)) ? '0 : j + 1'b1;

    assign hi       = j >= AW'(QTR);
    assign m        = AW'({(hi ? j - AW'(QTR) : j), 1'b0});
    assign tw_idx   = 32'(stage) * 32'(HALF) + 32'(k);

    assign busy     = state != IDLE;
    assign done     = (state == DONE) && !hold;
    assign rd_en    = (state == READ) && !hold;
    assign tw_en    = rd_en;
    assign rd_pair  = stage[0];
    assign rd_addr  = k;
    assign tw_addr  = TW_AW'(inv ? 32'(TW_LAST) - tw_idx : tw_idx);
    assign wr_en    = wr_raw && !hold;
    assign wr_bank  = busy ? dst_bank(stage[0], hi) : 2'd0;
    assign wr_addr0 = m;
    assign wr_addr1 = busy ? (m | AW'(1)) : '0;

endmodule

// File: tb/tb_ntt_agu.sv
// tb_ntt_agu: scoreboard bench for ntt_agu with LOGN=4, BFU_LAT=3
module tb_ntt_agu;

    localparam int LOGN    = 4;
    localparam int BFU_LAT = 3;
    localparam int AW      = 3;
    localparam int TW_AW   = 5;
    localparam int HALF    = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              inverse = 1'b0;
    logic              hold = 1'b0;
    logic              busy, done, rd_en, rd_pair, tw_en, wr_en;
    logic [2:0]        stage;
    logic [AW-1:0]     rd_addr, wr_addr0, wr_addr1;
    logic [TW_AW-1:0]  tw_addr;
    logic [1:0]        wr_bank;

    int          cyc = 0;
    int          t0 = 0;
    int          exp_lat = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    bit          active = 0;
    bit          done_seen = 0;
    logic [31:0] rd_q[$];
    logic [31:0] wr_q[$];

    ntt_agu #(.LOGN(LOGN), .BFU_LAT(BFU_LAT), .AW(AW), .TW_AW(TW_AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .inverse(inverse), .hold(hold),
        .busy(busy), .done(done), .stage(stage), .rd_en(rd_en), .rd_pair(rd_pair),
        .rd_addr(rd_addr), .tw_en(tw_en), .tw_addr(tw_addr), .wr_en(wr_en),
        .wr_bank(wr_bank), .wr_addr0(wr_addr0), .wr_addr1(wr_addr1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] all_outs();
        return 32'({busy, done, stage, rd_en, rd_pair, rd_addr, tw_en, tw_addr,
                    wr_en, wr_bank, wr_addr0, wr_addr1});
    endfunction

    task automatic push_tx(input bit inv);
        for (int s = 0; s < LOGN; s++) begin
            int p = s % 2;
            for (int k = 0; k < HALF; k++) begin
                int idx = s * HALF + k;
                int tw  = inv ? LOGN * HALF - 1 - idx : idx;
                rd_q.push_back({8'(s), 8'(p), 8'(k), 8'(tw)});
            end
            for (int j = 0; j < HALF; j++) begin
                int bank = (p == 1 ? 0 : 2) + (j >= HALF / 2 ? 1 : 0);
                int m    = 2 * (j % (HALF / 2));
                wr_q.push_back({8'(bank), 8'(m), 8'(m + 1), 8'd0});
            end
        end
    endtask

    always @(negedge clk) if (rst_n) begin
        if (hold)
            check("hold_strobes", 32'({rd_en, tw_en, wr_en}), 32'd0);
        if (rd_en) begin
            check("tw_en", 32'(tw_en), 32'd1);
            if (rd_q.size() == 0) check("rd_extra", 32'd1, 32'd0);
            else check("rd", {8'(stage), 8'(rd_pair), 8'(rd_addr), 8'(tw_addr)}, rd_q.pop_front());
        end
        if (wr_en) begin
            if (wr_q.size() == 0) check("wr_extra", 32'd1, 32'd0);
            else check("wr", {8'(wr_bank), 8'(wr_addr0), 8'(wr_addr1), 8'd0}, wr_q.pop_front());
        end
        if (done) begin
            check("done_expected", 32'(active), 32'd1);
            check("done_latency", 32'(cyc - t0), 32'(exp_lat));
            check("rd_q_empty", 32'(rd_q.size()), 32'd0);
            check("wr_q_empty", 32'(wr_q.size()), 32'd0);
            active    = 0;
            done_seen = 1;
        end
    end

    task automatic go(input bit inv, input int extra);
        @(posedge clk); #1;
        check("idle_before_start", 32'(busy), 32'd0);
        start     = 1'b1;
        inverse   = inv;
        t0        = cyc;
        exp_lat   = LOGN * (HALF + BFU_LAT) + 1 + extra;
        active    = 1;
        done_seen = 0;
        push_tx(inv);
        @(posedge clk); #1;
        start   = 1'b0;
        inverse = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done_seen && n < 300) begin
            @(posedge clk);
            n++;
        end
        if (!done_seen) check("done_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        check("idle_after_done", 32'(busy), 32'd0);
    endtask

    initial begin
        #12;
        check("reset_outputs", all_outs(), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        go(0, 0);
        wait_done();

        go(1, 0);
        wait_done();

        // stall while k=3 is being presented
        go(0, 5);
        repeat (3) @(posedge clk);
        #1;
        hold = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        hold = 1'b0;
        wait_done();

        // start (with inverse) pulsed mid-transform must be ignored
        go(0, 0);
        repeat (9) @(posedge clk);
        #1;
        start   = 1'b1;
        inverse = 1'b1;
        @(posedge clk); #1;
        start   = 1'b0;
        inverse = 1'b0;
        wait_done();

        // start under hold in IDLE must be ignored
        @(posedge clk); #1;
        hold  = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        hold  = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("hold_start_ignored", 32'(busy), 32'd0);

        // asynchronous reset during stage 2
        go(0, 0);
        repeat (24) @(posedge clk);
        #1;
        check("stage_before_reset", 32'(stage), 32'd2);
        rst_n = 1'b0;
        #1;
        check("reset_mid_outputs", all_outs(), 32'd0);
        active = 0;
        rd_q.delete();
        wr_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_after_reset", 32'(busy), 32'd0);
        go(0, 0);
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
